// File: rtl/arm_dmem_responder.sv
// Data-memory responder for the single-cycle ARM core.
// Word-organised RAM with byte lanes, console transmit FIFO, status register
// and an optional free-running cycle counter (enabled by DMEM_CYCLE_COUNTER_EN).
module arm_dmem_responder #(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        B,
   output logic [31:0] ReadData,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int unsigned PW        = $clog2(FIFO_DEPTH);
   localparam int unsigned CW        = PW + 1;
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [29:0] IO_WORD   = IO_BASE[31:2];

   // ---------------- address decode ----------------
   logic          ram_sel;
   logic          data_sel;
   logic          stat_sel;
   logic [AW-1:0] ram_idx;
   logic [4:0]    lane_sh;

   assign ram_sel  = (addr < RAM_BYTES);
   assign ram_idx  = addr[AW+1:2];
   assign lane_sh  = {addr[1:0], 3'b000};
   assign data_sel = (addr[31:2] == IO_WORD);
   assign stat_sel = (addr[31:2] == IO_WORD + 30'd1);

   // ---------------- data RAM ----------------
   logic [31:0] mem [RAM_WORDS];

   // RAM store: full word or a single little-endian lane; not affected by reset
   always_ff @(posedge clk) begin
      if (MemWrite && ram_sel) begin
         if (B) begin
            mem[ram_idx][lane_sh +: 8] <= WriteData[7:0];
         end else begin
            mem[ram_idx] <= WriteData;
         end
      end
   end

   // ---------------- console FIFO ----------------
   logic [7:0]    fifo [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic          pop;
   logic          push_req;
   logic          push_ok;
   logic          ovf_clr;

   assign tx_valid = (count != '0);
   assign tx_data  = fifo[rd_ptr];
   assign pop      = tx_valid && tx_ready;
   assign push_req = MemWrite && data_sel;
   // a pop in the same cycle frees a slot, so a full FIFO still accepts the push
   assign push_ok  = push_req && ((count < CW'(FIFO_DEPTH)) || pop);
   assign ovf_clr  = MemWrite && stat_sel;

   // FIFO entry write; suppressed while reset is sampled
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         fifo[wr_ptr] <= WriteData[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         unique case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (ovf_clr) begin
            ovf <= 1'b0;
         end else if (push_req && !push_ok) begin
            ovf <= 1'b1;
         end
      end
   end

   // ---------------- cycle counter ----------------
   logic [31:0] cycle_word;

`ifdef DMEM_CYCLE_COUNTER_EN
   logic        cyc_sel;
   logic [31:0] cycle_q;

   assign cyc_sel    = (addr[31:2] == IO_WORD + 30'd2);
   assign cycle_word = cyc_sel ? cycle_q : '0;

   // free-running counter, loadable by a word store
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
      end else if (MemWrite && !B && cyc_sel) begin
         cycle_q <= WriteData;
      end else begin
         cycle_q <= cycle_q + 32'd1;
      end
   end
`else
   assign cycle_word = '0;
`endif

   // ---------------- read path ----------------
   logic [31:0] status;
   logic [31:0] word_rd;

   // status register image
   always_comb begin
      status       = '0;
      status[0]    = (count == CW'(FIFO_DEPTH));
      status[1]    = !tx_valid;
      status[2]    = ovf;
      status[15:8] = 8'(count);
   end

   // combinational load mux; byte loads pick a lane of the selected word
   always_comb begin
      word_rd = '0;
      if (ram_sel) begin
         word_rd = mem[ram_idx];
      end else if (stat_sel) begin
         word_rd = status;
      end else begin
         word_rd = cycle_word;
      end
      ReadData = B ? {24'h000000, word_rd[lane_sh +: 8]} : word_rd;
   end

endmodule

// File: tb/tb_arm_dmem_responder.sv
// Self-checking bench for arm_dmem_responder: directed steps plus a random
// phase, all compared against a queue/array reference model.
module tb_arm_dmem_responder;

   localparam logic [31:0] IO    = 32'hFFFF_0000;
   localparam logic [29:0] IOW   = IO[31:2];
   localparam int          DEPTH = 8;
`ifdef DMEM_CYCLE_COUNTER_EN
   localparam bit CE = 1'b1;
`else
   localparam bit CE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] WriteData = '0;
   logic        MemWrite = 1'b0;
   logic        B = 1'b0;
   logic [31:0] ReadData;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;

   arm_dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH), .IO_BASE(IO)) dut (
      .clk(clk), .reset(reset), .addr(addr), .WriteData(WriteData),
      .MemWrite(MemWrite), .B(B), .ReadData(ReadData),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [31:0] ram [64];
   logic [7:0]  q[$];
   bit          ovf;
   logic [31:0] cyc;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] mread(input logic [31:0] a, input logic b);
      logic [31:0] w;
      if (a < 32'd256)                w = ram[a[7:2]];
      else if (a[31:2] == IOW + 30'd1) w = {16'h0, 8'(q.size()), 5'b0, ovf, q.size() == 0, q.size() == DEPTH};
      else if (a[31:2] == IOW + 30'd2) w = CE ? cyc : 32'h0;
      else                            w = 32'h0;
      if (b) w = (w >> (8 * a[1:0])) & 32'hFF;
      return w;
   endfunction

   task automatic model_update(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                               input logic b, input logic tr, input logic rst);
      int n;
      bit pop, push_req, stat_st, cyc_st;
      n        = q.size();
      pop      = (n > 0) && tr;
      push_req = mw && (a[31:2] == IOW);
      stat_st  = mw && (a[31:2] == IOW + 30'd1);
      cyc_st   = mw && !b && (a[31:2] == IOW + 30'd2);
      if (mw && a < 32'd256) begin
         if (b) ram[a[7:2]][a[1:0] * 8 +: 8] = wd[7:0];
         else   ram[a[7:2]] = wd;
      end
      if (rst) begin
         q.delete();
         ovf = 1'b0;
         cyc = 32'h0;
      end else begin
         if (pop) void'(q.pop_front());
         if (push_req) begin
            if (n < DEPTH || pop) q.push_back(wd[7:0]);
            else ovf = 1'b1;
         end
         if (stat_st) ovf = 1'b0;
         cyc = cyc_st ? wd : cyc + 32'd1;
      end
   endtask

   // drive one cycle, optionally check against the model, then advance
   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                       input logic b, input logic tr, input logic rst, input bit do_chk);
      addr = a; WriteData = wd; MemWrite = mw; B = b; tx_ready = tr; reset = rst;
      #2;
      if (do_chk) begin
         chk("ReadData", ReadData, mread(a, b));
         chk("tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
         if (q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, q[0]});
      end
      @(posedge clk);
      model_update(a, wd, mw, b, tr, rst);
      #1;
   endtask

   // combinational read probe within the current cycle, against a literal
   task automatic peek(input logic [31:0] a, input logic b, input string tag, input logic [31:0] exp);
      addr = a; B = b; MemWrite = 1'b0; reset = 1'b0;
      #1;
      chk(tag, ReadData, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int r;
      @(posedge clk); #1;
      step(32'h100, 0, 0, 0, 0, 1, 0);
      step(32'h100, 0, 0, 0, 0, 1, 0);
      // reset state
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      peek(IO + 4, 0, "rst_status", 32'h0000_0002);
      peek(IO + 8, 0, "rst_cycle", 32'h0);
      // preload RAM so every location has a known value
      for (int i = 0; i < 64; i++) step(i * 4, $urandom, 1, 0, 0, 0, 0);

      // word and byte RAM access
      step(32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 1);
      peek(32'h10, 0, "word_load", 32'hDEADBEEF);
      peek(32'h13, 1, "byte_load", 32'h0000_00DE);
      step(32'h11, 32'h0000_0055, 1, 1, 0, 0, 1);
      peek(32'h10, 0, "byte_store", 32'hDEAD55EF);
      step(32'h14, 0, 0, 0, 0, 0, 1);
      step(32'h0C, 0, 0, 0, 0, 0, 1);

      // fill FIFO, overflow, then drain
      for (int i = 0; i < 8; i++) step(IO, 32'h41 + i, 1, i[0], 0, 0, 1);
      step(IO, 32'h49, 1, 0, 0, 0, 1);
      peek(IO + 4, 0, "full_ovf_status", 32'h0000_0805);
      peek(IO, 0, "console_data_load", 32'h0);
      for (int i = 0; i < 8; i++) begin
         chk("drain_order", {24'b0, tx_data}, 32'h41 + i);
         step(IO + 4, 0, 0, 0, 1, 0, 1);
      end
      chk("drained_valid", {31'b0, tx_valid}, 32'h0);
      peek(IO + 4, 0, "drained_status", 32'h0000_0006);
      step(IO + 4, 0, 1, 1, 0, 0, 1);
      peek(IO + 4, 0, "ovf_cleared", 32'h0000_0002);

      // full FIFO with simultaneous pop and push
      for (int i = 0; i < 8; i++) step(IO, 32'h61 + i, 1, 0, 0, 0, 1);
      step(IO, 32'h5A, 1, 0, 1, 0, 1);
      peek(IO + 4, 0, "push_pop_full", 32'h0000_0801);
      for (int i = 0; i < 8; i++) begin
         chk("push_pop_order", {24'b0, tx_data}, (i < 7) ? 32'h62 + i : 32'h5A);
         step(IO + 4, 0, 0, 0, 1, 0, 1);
      end

      // cycle counter load and wrap
      step(IO + 8, 32'hFFFF_FFFE, 1, 0, 0, 0, 1);
      peek(IO + 8, 0, "cycle_load", CE ? 32'hFFFF_FFFE : 32'h0);
      step(IO + 8, 0, 0, 0, 0, 0, 1);
      peek(IO + 8, 0, "cycle_inc", CE ? 32'hFFFF_FFFF : 32'h0);
      step(IO + 8, 0, 0, 0, 0, 0, 1);
      peek(IO + 8, 0, "cycle_wrap", 32'h0);
      step(IO + 8, 0, 0, 0, 0, 0, 1);
      peek(IO + 8, 0, "cycle_after_wrap", CE ? 32'h1 : 32'h0);
      step(IO + 8, 32'h1234_5678, 1, 1, 0, 0, 1);   // byte store ignored
      step(IO + 9, 0, 0, 1, 0, 0, 1);
      step(IO + 8, 0, 0, 0, 0, 0, 1);

      // unmapped region
      step(32'h0000_1000, 32'hCAFE_F00D, 1, 0, 0, 0, 1);
      peek(32'h0000_1000, 0, "unmapped_load", 32'h0);
      step(IO + 12, 32'h1, 1, 0, 0, 0, 1);

      // reset mid-operation: 3 queued, ovf set, RAM store in the reset cycle
      for (int i = 0; i < 9; i++) step(IO, 32'h71 + i, 1, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(IO + 4, 0, 0, 0, 1, 0, 1);
      peek(IO + 4, 0, "pre_reset_status", 32'h0000_0304);
      step(32'h20, 32'h1234_5678, 1, 0, 0, 1, 1);
      chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
      peek(IO + 4, 0, "reset_status", 32'h0000_0002);
      peek(IO + 8, 0, "reset_cycle", 32'h0);
      peek(32'h10, 0, "reset_ram_kept", 32'hDEAD55EF);
      peek(32'h20, 0, "reset_ram_store", 32'h1234_5678);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: a = 32'($urandom_range(0, 255));
            4, 5:       a = IO + 32'($urandom_range(0, 3));
            6:          a = IO + 32'd4 + 32'($urandom_range(0, 3));
            7:          a = IO + 32'd8 + 32'($urandom_range(0, 3));
            8:          a = IO + 32'd12 + 32'($urandom_range(0, 255));
            default:    a = 32'h100 + 32'($urandom_range(0, 4095));
         endcase
         step(a, $urandom, ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0), 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
